// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 write-bus sequencer: state encoding,
// controller command bytes, init ROM contents and small helpers.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_INIT,
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_WAIT
  } lcd_state_e;

  localparam logic [7:0] FUNC_SET_8B2L = 8'h38;
  localparam logic [7:0] DISP_ON       = 8'h0C;
  localparam logic [7:0] CLEAR         = 8'h01;
  localparam logic [7:0] HOME          = 8'h02;
  localparam logic [7:0] ENTRY_INC     = 8'h06;

  localparam int unsigned INIT_ROM_DEPTH = 4;

  // Init sequence: 8-bit/2-line, display on, clear, entry mode increment
  function automatic logic [7:0] init_rom(input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = FUNC_SET_8B2L;
      2'd1:    b = DISP_ON;
      2'd2:    b = CLEAR;
      default: b = ENTRY_INC;
    endcase
    return b;
  endfunction

  // Clear and home are the only commands needing the long post-byte wait
  function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
    return !rs && ((data == CLEAR) || (data == HOME));
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_rr_arbiter.sv
// Two-way round-robin arbiter. Grants only while the sequencer is idle;
// the last-grant bit resets to 1 so requester 0 wins the first tie.
module lcd_rr_arbiter (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic idle,
  output logic grant,
  output logic valid
);

  logic last_grant;

  // Grant the requester not served last when both ask; otherwise the sole requester
  always_comb begin
    valid = idle && (req0 || req1);
    grant = (req0 && req1) ? ~last_grant : req1;
  end

  // Remember who was served on each accepted grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (valid) begin
      last_grant <= grant;
    end
  end

endmodule

// File: rtl/lcd_bus_sequencer.sv
// HD44780 8-bit write-bus owner: power-up wait, init sequence, then
// round-robin service of two byte requesters with full per-byte timing.
module lcd_bus_sequencer
  import lcd_pkg::*;
#(
  parameter int unsigned PWRUP_CYC = 1_000_000,
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned EN_CYC    = 25,
  parameter int unsigned HOLD_CYC  = 2,
  parameter int unsigned WAIT_CYC  = 2_500,
  parameter int unsigned CLR_CYC   = 100_000
) (
  input  logic       CLOCK_50,
  input  logic       RST,
  input  logic       req0,
  input  logic       rs0,
  input  logic [7:0] data0,
  output logic       ack0,
  input  logic       req1,
  input  logic       rs1,
  input  logic [7:0] data1,
  output logic       ack1,
  output logic       ready,
  output logic       busy,
  output logic [7:0] LCD_DATA,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_EN
);

  localparam int unsigned MAX_CYC = max_u(max_u(max_u(PWRUP_CYC, SETUP_CYC), max_u(EN_CYC, HOLD_CYC)),
                                          max_u(WAIT_CYC, CLR_CYC));
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  lcd_state_e       state, state_next;
  logic [CNT_W-1:0] cnt, cnt_load;
  logic             cnt_zero;
  logic [1:0]       idx;
  logic             ready_q;
  logic             rs_q;
  logic [7:0]       data_q;
  logic             grant, grant_valid;

  assign cnt_zero = (cnt == '0);

  lcd_rr_arbiter u_arb (
    .clk   (CLOCK_50),
    .rst   (RST),
    .req0  (req0),
    .req1  (req1),
    .idle  (state == ST_IDLE),
    .grant (grant),
    .valid (grant_valid)
  );

  // State register and timing counter, reloaded on every state change
  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      state <= ST_PWRUP;
      cnt   <= CNT_W'(PWRUP_CYC - 1);
    end else begin
      state <= state_next;
      if (state_next != state) begin
        cnt <= cnt_load;
      end else if (!cnt_zero) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  // Next-state logic and the counter value for the state being entered
  always_comb begin
    state_next = state;
    case (state)
      ST_PWRUP: if (cnt_zero) state_next = ST_INIT;
      ST_INIT:  state_next = ST_SETUP;
      ST_IDLE:  if (grant_valid) state_next = ST_SETUP;
      ST_SETUP: if (cnt_zero) state_next = ST_PULSE;
      ST_PULSE: if (cnt_zero) state_next = ST_HOLD;
      ST_HOLD:  if (cnt_zero) state_next = ST_WAIT;
      ST_WAIT:  if (cnt_zero) state_next = (!ready_q && idx != 2'd3) ? ST_INIT : ST_IDLE;
      default:  state_next = ST_PWRUP;
    endcase

    cnt_load = '0;
    case (state_next)
      ST_PWRUP: cnt_load = CNT_W'(PWRUP_CYC - 1);
      ST_SETUP: cnt_load = CNT_W'(SETUP_CYC - 1);
      ST_PULSE: cnt_load = CNT_W'(EN_CYC - 1);
      ST_HOLD:  cnt_load = CNT_W'(HOLD_CYC - 1);
      ST_WAIT:  cnt_load = is_slow_cmd(rs_q, data_q) ? CNT_W'(CLR_CYC - 1) : CNT_W'(WAIT_CYC - 1);
      default:  cnt_load = '0;
    endcase
  end

  // Latched byte, init step index and ready flag
  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      rs_q    <= 1'b0;
      data_q  <= '0;
      idx     <= '0;
      ready_q <= 1'b0;
    end else begin
      if (state == ST_INIT) begin
        rs_q   <= 1'b0;
        data_q <= init_rom(idx);
      end else if (state == ST_IDLE && grant_valid) begin
        rs_q   <= grant ? rs1 : rs0;
        data_q <= grant ? data1 : data0;
      end
      if (state == ST_WAIT && cnt_zero && !ready_q) begin
        if (idx == 2'd3) begin
          ready_q <= 1'b1;
        end else begin
          idx <= idx + 2'd1;
        end
      end
    end
  end

  // Outputs decoded from state and latched registers
  always_comb begin
    LCD_EN   = (state == ST_PULSE);
    LCD_RS   = rs_q;
    LCD_DATA = data_q;
    LCD_RW   = 1'b0;
    busy     = (state != ST_IDLE);
    ready    = ready_q;
    ack0     = grant_valid && !grant;
    ack1     = grant_valid && grant;
  end

endmodule
